// File: rtl/load_store_unit_if.sv
// Wishbone-classic data bus of the load/store unit, plus the memory-operation type shared with the control unit.
package load_store_unit_pkg;
   typedef enum logic [1:0] {
      MEM_NONE   = 2'd0,
      LOAD_DATA  = 2'd1,
      STORE_DATA = 2'd2
   } memory_operation_t;
endpackage

interface load_store_unit_if;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one registered Wishbone-classic access at a time; build option LSU_MISALIGN_TRAP_EN.
// Latency: load ack at accept, data_valid one cycle after wb_ack_i; store ack one cycle after wb_ack_i.
// Backpressure: cyc is held by the control unit until ack; requests are only sampled in IDLE.
module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cyc,
   input  memory_operation_t memory_operation,
   input  logic [2:0]        funct3,
   input  logic [31:0]       rs1_data,
   input  logic [31:0]       rs2_data,
   input  logic [11:0]       i_imm,
   input  logic [11:0]       s_imm,
   output logic              ack,
   output logic              data_valid,
   output logic [31:0]       load_data,
   output logic              misaligned,
   load_store_unit_if.master wb
);
   typedef enum logic [1:0] {IDLE, LOAD_BUS, STORE_BUS, LOAD_RESP} state_t;

   state_t      state;
   logic [31:0] adr_q, dat_q;
   logic [3:0]  sel_q;
   logic        we_q, bus_q, fault_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   logic        is_load, is_store, legal, fault;
   logic [11:0] imm;
   logic [31:0] ea, sdat, shifted, ext;
   logic [1:0]  off;
   logic [3:0]  sel;

   assign is_load  = cyc && (memory_operation == LOAD_DATA);
   assign is_store = cyc && (memory_operation == STORE_DATA);
   assign imm      = is_store ? s_imm : i_imm;
   assign ea       = rs1_data + {{20{imm[11]}}, imm};

   always_comb begin
      if (is_store) legal = funct3 inside {3'b000, 3'b001, 3'b010};
      else          legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign fault = ((funct3[1:0] == 2'b01) && ea[0]) ||
                  ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
   assign off   = ea[1:0];
`else
   // Misaligned halves/words drop the offending low bits and proceed.
   assign fault = 1'b0;
   always_comb begin
      case (funct3[1:0])
         2'b00:   off = ea[1:0];
         2'b01:   off = {ea[1], 1'b0};
         default: off = 2'b00;
      endcase
   end
`endif

   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            sel  = 4'b0001 << off;
            sdat = {4{rs2_data[7:0]}};
         end
         2'b01: begin
            sel  = off[1] ? 4'b1100 : 4'b0011;
            sdat = {2{rs2_data[15:0]}};
         end
         default: begin
            sel  = 4'b1111;
            sdat = rs2_data;
         end
      endcase
   end

   assign shifted = wb.wb_dat_i >> {off_q, 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ext = {24'b0, shifted[7:0]};
         3'b101:  ext = {16'b0, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         ack        <= 1'b0;
         data_valid <= 1'b0;
         misaligned <= 1'b0;
         load_data  <= 32'b0;
         adr_q      <= 32'b0;
         dat_q      <= 32'b0;
         sel_q      <= 4'b0;
         we_q       <= 1'b0;
         bus_q      <= 1'b0;
         fault_q    <= 1'b0;
         f3_q       <= 3'b0;
         off_q      <= 2'b0;
      end else begin
         ack        <= 1'b0;
         data_valid <= 1'b0;
         misaligned <= 1'b0;
         case (state)
            IDLE: begin
               if (is_load || is_store) begin
                  f3_q    <= funct3;
                  off_q   <= off;
                  fault_q <= fault;
                  if (!legal || fault) begin
                     ack <= 1'b1;
                     if (is_load) state      <= LOAD_RESP;
                     else         misaligned <= fault;
                  end else begin
                     adr_q <= {ea[31:2], 2'b00};
                     sel_q <= sel;
                     dat_q <= is_store ? sdat : 32'b0;
                     we_q  <= is_store;
                     bus_q <= 1'b1;
                     if (is_load) begin
                        ack   <= 1'b1;
                        state <= LOAD_BUS;
                     end else begin
                        state <= STORE_BUS;
                     end
                  end
               end
            end
            LOAD_BUS, STORE_BUS: begin
               if (wb.wb_ack_i) begin
                  bus_q <= 1'b0;
                  we_q  <= 1'b0;
                  adr_q <= 32'b0;
                  sel_q <= 4'b0;
                  dat_q <= 32'b0;
                  state <= IDLE;
                  if (state == LOAD_BUS) begin
                     load_data  <= ext;
                     data_valid <= 1'b1;
                  end else begin
                     ack <= 1'b1;
                  end
               end
            end
            LOAD_RESP: begin
               load_data  <= 32'b0;
               data_valid <= 1'b1;
               misaligned <= fault_q;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_sel_o = sel_q;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_cyc_o = bus_q;
   assign wb.wb_stb_o = bus_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a scripted zero/k-wait Wishbone slave.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cyc = 1'b0;
   memory_operation_t memory_operation = MEM_NONE;
   logic [2:0]        funct3 = 3'b0;
   logic [31:0]       rs1_data = 32'b0;
   logic [31:0]       rs2_data = 32'b0;
   logic [11:0]       i_imm = 12'b0;
   logic [11:0]       s_imm = 12'b0;
   logic              ack, data_valid, misaligned;
   logic [31:0]       load_data;

   localparam logic [31:0] GARBAGE = 32'h5A5A_5A5A;

   load_store_unit_if wb_bus();

   load_store_unit dut (
      .clk(clk), .rst(rst), .cyc(cyc), .memory_operation(memory_operation),
      .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .i_imm(i_imm), .s_imm(s_imm), .ack(ack), .data_valid(data_valid),
      .load_data(load_data), .misaligned(misaligned), .wb(wb_bus)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] last_ld = 32'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      memory_operation_t op;
      logic [2:0]  f3;
      logic [31:0] rs1, rs2;
      logic [11:0] iimm, simm;
      int          waits;
      logic [31:0] rdata;
      bit          bus;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] ld;
      bit          mis;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input memory_operation_t op, input logic [2:0] f3,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [11:0] iimm, input logic [11:0] simm,
                      input int waits, input logic [31:0] rdata, input bit bus,
                      input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input logic [31:0] ld, input bit mis);
      vec_t v;
      v = '{op, f3, rs1, rs2, iimm, simm, waits, rdata, bus, adr, sel, dat, ld, mis};
      vecs.push_back(v);
   endtask

   task automatic run(input vec_t v, input string tag);
      bit is_ld;
      is_ld = (v.op == LOAD_DATA);
      @(negedge clk);
      cyc = 1'b1; memory_operation = v.op; funct3 = v.f3;
      rs1_data = v.rs1; rs2_data = v.rs2; i_imm = v.iimm; s_imm = v.simm;
      @(posedge clk); #1;
      chk({tag, "_cyc"}, 32'(wb_bus.wb_cyc_o), 32'(v.bus));
      chk({tag, "_ack_accept"}, 32'(ack), 32'(is_ld || !v.bus));
      if (v.bus) begin
         chk({tag, "_adr"}, wb_bus.wb_adr_o, v.adr);
         chk({tag, "_sel"}, 32'(wb_bus.wb_sel_o), 32'(v.sel));
         chk({tag, "_we"}, 32'(wb_bus.wb_we_o), 32'(!is_ld));
         chk({tag, "_stb"}, 32'(wb_bus.wb_stb_o), 32'(1'b1));
         if (!is_ld) chk({tag, "_wdat"}, wb_bus.wb_dat_o, v.dat);
         if (v.waits == 0) begin wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = v.rdata; end
      end else if (!is_ld) begin
         chk({tag, "_mis"}, 32'(misaligned), 32'(v.mis));
      end
      @(negedge clk);
      // Control unit drops the request; scrambled inputs must be ignored.
      cyc = 1'b0; funct3 = 3'b111; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'h0;
      if (v.bus) begin
         for (int i = 1; i <= v.waits; i++) begin
            @(posedge clk); #1;
            chk({tag, "_wait_cyc"}, 32'(wb_bus.wb_cyc_o), 32'(1'b1));
            chk({tag, "_wait_idle"}, 32'({ack, data_valid}), 32'(2'b00));
            if (i == v.waits) begin wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = v.rdata; end
         end
         @(posedge clk); #1;
         wb_bus.wb_ack_i = 1'b0; wb_bus.wb_dat_i = GARBAGE;
         chk({tag, "_done_cyc"}, 32'(wb_bus.wb_cyc_o), 32'(1'b0));
         chk({tag, "_done_ack_dv"}, 32'({ack, data_valid}), is_ld ? 32'(2'b01) : 32'(2'b10));
         chk({tag, "_done_mis"}, 32'(misaligned), 32'(v.mis));
         if (is_ld) last_ld = v.ld;
         chk({tag, "_load_data"}, load_data, last_ld);
      end else if (is_ld) begin
         @(posedge clk); #1;
         chk({tag, "_resp_dv"}, 32'({ack, data_valid}), 32'(2'b01));
         chk({tag, "_resp_mis"}, 32'(misaligned), 32'(v.mis));
         chk({tag, "_resp_cyc"}, 32'(wb_bus.wb_cyc_o), 32'(1'b0));
         last_ld = 32'b0;
         chk({tag, "_load_data"}, load_data, last_ld);
      end
      @(posedge clk); #1;
      chk({tag, "_pulse_end"}, 32'({ack, data_valid, misaligned}), 32'(3'b000));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      wb_bus.wb_ack_i = 1'b0;
      wb_bus.wb_dat_i = GARBAGE;

      //  op          f3      rs1           rs2           iimm    simm    w  rdata         bus adr           sel      dat           ld            mis
      add(LOAD_DATA,  3'b010, 32'h0000_0100, 32'h0,        12'h004, 12'h7F0, 0, 32'hDEAD_BEEF, 1, 32'h0000_0104, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0);
      add(LOAD_DATA,  3'b000, 32'h0000_0100, 32'h0,        12'h003, 12'h000, 0, 32'h8012_3456, 1, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80, 0);
      add(LOAD_DATA,  3'b100, 32'h0000_0100, 32'h0,        12'h003, 12'h000, 0, 32'h8012_3456, 1, 32'h0000_0100, 4'b1000, 32'h0,        32'h0000_0080, 0);
      add(STORE_DATA, 3'b001, 32'h0000_0200, 32'h1234_ABCD, 12'h7FF, 12'h002, 3, GARBAGE,       1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0,        0);
      add(LOAD_DATA,  3'b001, 32'h0000_1000, 32'h0,        12'hFFE, 12'h000, 1, 32'h8001_7FFF, 1, 32'h0000_0FFC, 4'b1100, 32'h0,        32'hFFFF_8001, 0);
      add(LOAD_DATA,  3'b101, 32'h0000_0010, 32'h0,        12'h000, 12'h004, 0, 32'h1234_F00D, 1, 32'h0000_0010, 4'b0011, 32'h0,        32'h0000_F00D, 0);
      add(STORE_DATA, 3'b000, 32'h0000_0300, 32'h0000_00A5, 12'h010, 12'h001, 0, GARBAGE,       1, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0,        0);
      add(STORE_DATA, 3'b010, 32'hFFFF_FFFC, 32'hCAFE_F00D, 12'h7FF, 12'h008, 2, GARBAGE,       1, 32'h0000_0004, 4'b1111, 32'hCAFE_F00D, 32'h0,        0);
`ifdef LSU_MISALIGN_TRAP_EN
      add(LOAD_DATA,  3'b010, 32'h0000_0101, 32'h0,        12'h000, 12'h000, 0, 32'h1122_3344, 0, 32'h0,         4'b0000, 32'h0,        32'h0,         1);
`else
      add(LOAD_DATA,  3'b010, 32'h0000_0101, 32'h0,        12'h000, 12'h000, 0, 32'h1122_3344, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'h1122_3344, 0);
`endif
      add(LOAD_DATA,  3'b000, 32'h0000_0100, 32'h0,        12'h001, 12'h000, 0, 32'h0000_C300, 1, 32'h0000_0100, 4'b0010, 32'h0,        32'hFFFF_FFC3, 0);
      add(LOAD_DATA,  3'b011, 32'h0000_0100, 32'h0,        12'h000, 12'h000, 0, GARBAGE,       0, 32'h0,         4'b0000, 32'h0,        32'h0,         0);
      add(STORE_DATA, 3'b100, 32'h0000_0100, 32'h5555_5555, 12'h000, 12'h000, 0, GARBAGE,       0, 32'h0,         4'b0000, 32'h0,        32'h0,         0);

      // Reset state
      #2;
      chk("rst_ack_dv_mis", 32'({ack, data_valid, misaligned}), 32'(3'b000));
      chk("rst_load_data", load_data, 32'h0);
      chk("rst_bus", 32'({wb_bus.wb_cyc_o, wb_bus.wb_stb_o, wb_bus.wb_we_o, wb_bus.wb_sel_o}), 32'(7'b0));
      chk("rst_adr", wb_bus.wb_adr_o, 32'h0);
      chk("rst_wdat", wb_bus.wb_dat_o, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // MEM_NONE with cyc high and a stray wb_ack_i in IDLE: nothing happens
      cyc = 1'b1; memory_operation = MEM_NONE; funct3 = 3'b010; rs1_data = 32'h100;
      wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = 32'h1234_5678;
      repeat (2) begin
         @(posedge clk); #1;
         chk("none_outputs", 32'({ack, data_valid, wb_bus.wb_cyc_o}), 32'(3'b000));
      end
      chk("none_load_data", load_data, 32'h0);
      @(negedge clk);
      cyc = 1'b0; wb_bus.wb_ack_i = 1'b0; wb_bus.wb_dat_i = GARBAGE;

      for (int i = 0; i < vecs.size(); i++) run(vecs[i], $sformatf("v%0d", i));

      // Reset asserted mid LOAD_BUS: bus drops asynchronously, no completion
      @(negedge clk);
      cyc = 1'b1; memory_operation = LOAD_DATA; funct3 = 3'b010; rs1_data = 32'h40; i_imm = 12'h0;
      @(posedge clk); #1;
      chk("midrst_cyc_before", 32'(wb_bus.wb_cyc_o), 32'(1'b1));
      @(negedge clk);
      cyc = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("midrst_cyc_async", 32'(wb_bus.wb_cyc_o), 32'(1'b0));
      chk("midrst_ack", 32'(ack), 32'(1'b0));
      wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = 32'h7777_7777;
      @(posedge clk); #1;
      chk("midrst_no_dv", 32'({ack, data_valid}), 32'(2'b00));
      chk("midrst_load_data", load_data, 32'h0);
      wb_bus.wb_ack_i = 1'b0; wb_bus.wb_dat_i = GARBAGE;
      @(negedge clk);
      rst = 1'b1;
      last_ld = 32'h0;
      run(vecs[0], "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
